// File: rtl/cluster_event_buffer.sv
// Per-core cluster event buffer: maps event sources into a 32-bit layout, latches them
// into sticky pending bits, and drives a masked wake request plus a saturating lost-event count.

module cluster_event_lane #(
    parameter int          NB_CL_EVT    = 2,
    parameter logic [7:0]  CL_EDGE_MASK = 8'h00,
    parameter int          LOST_CNT_W   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [31:0]           i_lvl,
    input  logic [31:0]           i_mask,
    input  logic [31:0]           i_clear,
    input  logic                  i_lost_clr,
    output logic [31:0]           o_pending,
    output logic                  o_wake,
    output logic [LOST_CNT_W-1:0] o_lost_cnt
);
    localparam logic [LOST_CNT_W-1:0] CNT_MAX = {LOST_CNT_W{1'b1}};

    logic [NB_CL_EVT-1:0]  w_cl;
    logic [31:0]           w_ev;
    logic                  w_lost;
    logic [31:0]           r_pend;
    logic [LOST_CNT_W-1:0] r_cnt;

    // Only edge-mode cluster bits carry a history flop.
    for (genvar i = 0; i < NB_CL_EVT; i++) begin : g_cl
        if (CL_EDGE_MASK[i]) begin : g_edge
            logic r_prev;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) r_prev <= 1'b0;
                else         r_prev <= i_lvl[19+i];
            end
            assign w_cl[i] = i_lvl[19+i] & ~r_prev;
        end else begin : g_lvl
            assign w_cl[i] = i_lvl[19+i];
        end
    end

    always_comb begin
        w_ev                  = i_lvl;
        w_ev[19 +: NB_CL_EVT] = w_cl;
    end

    assign w_lost = |(w_ev & r_pend & ~i_clear);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            r_pend <= w_ev | (r_pend & ~i_clear);
            if (i_lost_clr)                    r_cnt <= '0;
            else if (w_lost && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_pending  = r_pend;
    assign o_wake     = |(r_pend & i_mask);
    assign o_lost_cnt = r_cnt;
endmodule

module cluster_event_buffer #(
    parameter int         NB_CORES     = 8,
    parameter int         NB_CL_EVT    = 2,
    parameter logic [7:0] CL_EDGE_MASK = 8'h00,
    parameter int         LOST_CNT_W   = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NB_CORES-1:0][7:0]             sw_events_i,
    input  logic [NB_CORES-1:0][1:0]             dma_events_i,
    input  logic [NB_CORES-1:0][1:0]             timer_events_i,
    input  logic [NB_CORES-1:0][3:0]             acc_events_i,
    input  logic [NB_CORES-1:0]                  barrier_events_i,
    input  logic [NB_CORES-1:0]                  mutex_events_i,
    input  logic [NB_CORES-1:0]                  dispatch_events_i,
    input  logic [NB_CORES-1:0][NB_CL_EVT-1:0]   cluster_events_i,
    input  logic                                 periph_fifo_event_i,
    input  logic [NB_CORES-1:0][31:0]            evt_mask_i,
    input  logic [NB_CORES-1:0][31:0]            evt_clear_i,
    input  logic [NB_CORES-1:0]                  lost_clr_i,
    output logic [NB_CORES-1:0][31:0]            pending_o,
    output logic [NB_CORES-1:0]                  wake_o,
    output logic [NB_CORES-1:0][LOST_CNT_W-1:0]  lost_cnt_o
);
    logic [NB_CORES-1:0][31:0] w_lvl;

    // Raw level map; reserved bits stay zero so they can never become pending.
    always_comb begin
        for (int c = 0; c < NB_CORES; c++) begin
            w_lvl[c]                  = '0;
            w_lvl[c][7:0]             = sw_events_i[c];
            w_lvl[c][9:8]             = dma_events_i[c];
            w_lvl[c][11:10]           = timer_events_i[c];
            w_lvl[c][15:12]           = acc_events_i[c];
            w_lvl[c][16]              = barrier_events_i[c];
            w_lvl[c][17]              = mutex_events_i[c];
            w_lvl[c][18]              = dispatch_events_i[c];
            w_lvl[c][19 +: NB_CL_EVT] = cluster_events_i[c];
            w_lvl[c][27]              = periph_fifo_event_i;
        end
    end

    for (genvar c = 0; c < NB_CORES; c++) begin : g_core
        cluster_event_lane #(
            .NB_CL_EVT    (NB_CL_EVT),
            .CL_EDGE_MASK (CL_EDGE_MASK),
            .LOST_CNT_W   (LOST_CNT_W)
        ) u_lane (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .i_lvl      (w_lvl[c]),
            .i_mask     (evt_mask_i[c]),
            .i_clear    (evt_clear_i[c]),
            .i_lost_clr (lost_clr_i[c]),
            .o_pending  (pending_o[c]),
            .o_wake     (wake_o[c]),
            .o_lost_cnt (lost_cnt_o[c])
        );
    end
endmodule

// File: tb/tb_cluster_event_buffer.sv
// Bench for cluster_event_buffer: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural pending/lost model.

module tb_cluster_event_buffer;
    localparam int         NC   = 8;
    localparam int         NCL  = 2;
    localparam logic [7:0] EDGE = 8'h01;
    localparam int         LW   = 4;
    localparam int         CMAX = (1 << LW) - 1;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic [NC-1:0][7:0]        sw;
    logic [NC-1:0][1:0]        dma, tmr;
    logic [NC-1:0][3:0]        acc;
    logic [NC-1:0]             bar, mtx, dsp;
    logic [NC-1:0][NCL-1:0]    cl;
    logic                      periph;
    logic [NC-1:0][31:0]       mask, clr;
    logic [NC-1:0]             lclr;
    logic [NC-1:0][31:0]       pending_o;
    logic [NC-1:0]             wake_o;
    logic [NC-1:0][LW-1:0]     lost_cnt_o;

    cluster_event_buffer #(.NB_CORES(NC), .NB_CL_EVT(NCL), .CL_EDGE_MASK(EDGE), .LOST_CNT_W(LW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .sw_events_i(sw), .dma_events_i(dma), .timer_events_i(tmr), .acc_events_i(acc),
        .barrier_events_i(bar), .mutex_events_i(mtx), .dispatch_events_i(dsp),
        .cluster_events_i(cl), .periph_fifo_event_i(periph),
        .evt_mask_i(mask), .evt_clear_i(clr), .lost_clr_i(lclr),
        .pending_o(pending_o), .wake_o(wake_o), .lost_cnt_o(lost_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // Behavioural model state.
    logic [31:0]    m_pend [NC];
    int             m_cnt  [NC];
    logic [NCL-1:0] m_prev [NC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] event_word(input int c);
        logic [31:0] e = '0;
        e[7:0]   = sw[c];
        e[9:8]   = dma[c];
        e[11:10] = tmr[c];
        e[15:12] = acc[c];
        e[16]    = bar[c];
        e[17]    = mtx[c];
        e[18]    = dsp[c];
        for (int i = 0; i < NCL; i++)
            e[19+i] = EDGE[i] ? (cl[c][i] & ~m_prev[c][i]) : cl[c][i];
        e[27]    = periph;
        return e;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NC; c++) begin
                m_pend[c] = '0; m_cnt[c] = 0; m_prev[c] = '0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                logic [31:0] e;
                bit lost;
                e    = event_word(c);
                lost = |(e & m_pend[c] & ~clr[c]);
                m_pend[c] = e | (m_pend[c] & ~clr[c]);
                if (lclr[c])                   m_cnt[c] = 0;
                else if (lost && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
                m_prev[c] = cl[c];
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk_i) begin
        if (chk_en) begin
            for (int c = 0; c < NC; c++) begin
                chk($sformatf("model pend[%0d]", c), pending_o[c], m_pend[c]);
                chk($sformatf("model lost[%0d]", c), 32'(lost_cnt_o[c]), 32'(m_cnt[c]));
                chk($sformatf("model wake[%0d]", c), 32'(wake_o[c]), 32'(|(m_pend[c] & mask[c])));
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle();
        sw = '0; dma = '0; tmr = '0; acc = '0; bar = '0; mtx = '0; dsp = '0;
        cl = '0; periph = 1'b0; clr = '0; lclr = '0;
    endtask

    task automatic rand_drive();
        for (int c = 0; c < NC; c++) begin
            sw[c]   = 8'($urandom & $urandom & $urandom);
            dma[c]  = 2'($urandom & $urandom);
            tmr[c]  = 2'($urandom & $urandom);
            acc[c]  = 4'($urandom & $urandom);
            bar[c]  = ($urandom_range(0, 3) == 0);
            mtx[c]  = ($urandom_range(0, 3) == 0);
            dsp[c]  = ($urandom_range(0, 3) != 0);
            cl[c]   = NCL'($urandom);
            mask[c] = $urandom & $urandom;
            clr[c]  = $urandom & $urandom & $urandom;
            lclr[c] = ($urandom_range(0, 15) == 0);
        end
        periph = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        mask = '0;
        #1 chk_en = 1'b1;
        #21 rst_ni = 1'b1;
        step();
        chk("reset pend2", pending_o[2], 32'h0);
        chk("reset lost2", 32'(lost_cnt_o[2]), 32'h0);
        chk("reset wake", 32'(wake_o), 32'h0);

        // Single software pulse with matching mask.
        sw[2][5] = 1'b1; mask[2] = 32'h20;
        step(); idle();
        chk("sw pulse pend2", pending_o[2], 32'h20);
        chk("sw pulse wake", 32'(wake_o), 32'h04);
        chk("sw pulse pend3", pending_o[3], 32'h0);

        // New event with simultaneous clear: set wins, no loss.
        sw[2][5] = 1'b1; clr[2][5] = 1'b1;
        step(); idle();
        chk("set beats clear pend2", pending_o[2], 32'h20);
        chk("set beats clear lost2", 32'(lost_cnt_o[2]), 32'h0);
        clr[2] = 32'h20;
        step(); idle();
        chk("clear pend2", pending_o[2], 32'h0);
        chk("clear wake", 32'(wake_o), 32'h0);

        // Edge-mode cluster bit held for five cycles, cleared on cycle 3.
        cl[0][0] = 1'b1;
        step();
        chk("edge set pend0", pending_o[0], 32'h0008_0000);
        step();
        clr[0][19] = 1'b1;
        step();
        clr = '0;
        step(); step();
        chk("edge held pend0", pending_o[0], 32'h0);
        chk("edge held lost0", 32'(lost_cnt_o[0]), 32'h0);
        idle();

        // Level barrier held 20 cycles: saturates the lost counter.
        bar[1] = 1'b1;
        repeat (20) step();
        chk("barrier pend1", pending_o[1], 32'h0001_0000);
        chk("barrier sat lost1", 32'(lost_cnt_o[1]), 32'd15);
        bar[1] = 1'b0; lclr[1] = 1'b1; clr[1] = 32'h0001_0000;
        step(); idle();
        chk("lost clear lost1", 32'(lost_cnt_o[1]), 32'h0);
        chk("lost clear pend1", pending_o[1], 32'h0);

        // Broadcast periph event with all masks off, then unmask core 3 only.
        mask = '0; periph = 1'b1;
        step(); idle();
        for (int c = 0; c < NC; c++)
            chk($sformatf("periph pend[%0d]", c), pending_o[c], 32'h0800_0000);
        chk("periph masked wake", 32'(wake_o), 32'h0);
        mask[3] = 32'h0800_0000;
        #1 chk("periph mask comb wake", 32'(wake_o), 32'h08);
        clr = '1;
        step(); idle();

        // Build up state, then async reset without a clock edge.
        mask[4] = 32'h1; sw[4][0] = 1'b1; cl[5][0] = 1'b1;
        step(); step(); step();
        chk("pre-reset lost4", 32'(lost_cnt_o[4]), 32'd2);
        #1 rst_ni = 1'b0;
        #1;
        chk("async reset pend", 32'(|pending_o), 32'h0);
        chk("async reset lost", 32'(|lost_cnt_o), 32'h0);
        chk("async reset wake", 32'(wake_o), 32'h0);
        rst_ni = 1'b1;
        sw = '0;
        step();
        chk("post-reset edge pend5", pending_o[5], 32'h0008_0000);
        idle();

        repeat (600) begin
            rand_drive();
            step();
        end
        idle();
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
